// File: rtl/sort5_pkg.sv
// Shared definitions for the Sort5 slave register map and the stream adapter FSM.
package sort5_pkg;

   localparam logic [3:0] SORT5_ADDR_IN0     = 4'd0;
   localparam logic [3:0] SORT5_ADDR_START   = 4'd5;
   localparam logic [3:0] SORT5_ADDR_SORTED0 = 4'd6;
   localparam logic [3:0] SORT5_ADDR_SORTED4 = 4'd10;
   localparam logic [3:0] SORT5_ADDR_MEDIAN  = 4'd8;

   localparam int SORT5_NUM_WORDS = 5;

   typedef enum logic [2:0] {
      COLLECT,
      WRITE,
      START,
      SETTLE,
      READ,
      CAPTURE,
      EMIT
   } sort5_state_t;

endpackage

// File: rtl/sort5_stream_adapter.sv
// Stream-to-Avalon-MM master for the Sort5 slave: collect 5 words, sort, stream back.
// Build option SORT5_ADAPT_MEDIAN_ONLY_EN: read and emit only the median word.
module sort5_stream_adapter
   import sort5_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic                  iClk,
   input  logic                  iReset_n,
   input  logic                  iInValid,
   output logic                  oInReady,
   input  logic [DATA_WIDTH-1:0] iInData,
   output logic                  oOutValid,
   input  logic                  iOutReady,
   output logic [DATA_WIDTH-1:0] oOutData,
   output logic                  oOutLast,
   output logic                  oChipSelect_n,
   output logic                  oWrite_n,
   output logic                  oRead_n,
   output logic [3:0]            oAddress,
   output logic [DATA_WIDTH-1:0] oWriteData,
   input  logic [DATA_WIDTH-1:0] iReadData,
   output logic                  oBusy
);

`ifdef SORT5_ADAPT_MEDIAN_ONLY_EN
   localparam logic [3:0] RD_FIRST = SORT5_ADDR_MEDIAN;
   localparam logic [3:0] RD_LAST  = SORT5_ADDR_MEDIAN;
`else
   localparam logic [3:0] RD_FIRST = SORT5_ADDR_SORTED0;
   localparam logic [3:0] RD_LAST  = SORT5_ADDR_SORTED4;
`endif

   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [2:0] LAST_WORD = 3'(SORT5_NUM_WORDS - 1);

   sort5_state_t          r_state;
   logic [2:0]            r_cnt;
   logic [SW-1:0]         r_settle;
   logic [3:0]            r_idx;
   logic [DATA_WIDTH-1:0] r_buf [SORT5_NUM_WORDS];

   logic                  r_in_ready;
   logic                  r_out_valid;
   logic                  r_out_last;
   logic [DATA_WIDTH-1:0] r_out_data;
   logic                  r_cs_n;
   logic                  r_wr_n;
   logic                  r_rd_n;
   logic [3:0]            r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  r_busy;

   // Bus strobes default to idle every cycle, so each access lasts exactly one cycle;
   // a state sets them on the edge that enters the state which owns the access.
   always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n) begin
         r_state     <= COLLECT;
         r_cnt       <= '0;
         r_settle    <= '0;
         r_idx       <= '0;
         for (int i = 0; i < SORT5_NUM_WORDS; i++) r_buf[i] <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_data  <= '0;
         r_cs_n      <= 1'b1;
         r_wr_n      <= 1'b1;
         r_rd_n      <= 1'b1;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_busy      <= 1'b0;
      end else begin
         r_cs_n <= 1'b1;
         r_wr_n <= 1'b1;
         r_rd_n <= 1'b1;
         case (r_state)
            COLLECT: begin
               if (iInValid && r_in_ready) begin
                  r_buf[r_cnt] <= iInData;
                  if (r_cnt == LAST_WORD) begin
                     r_cnt      <= '0;
                     r_in_ready <= 1'b0;
                     r_busy     <= 1'b1;
                     r_state    <= WRITE;
                     r_cs_n     <= 1'b0;
                     r_wr_n     <= 1'b0;
                     r_addr     <= SORT5_ADDR_IN0;
                     r_wdata    <= r_buf[0];
                  end else begin
                     r_cnt <= r_cnt + 3'd1;
                  end
               end
            end
            WRITE: begin
               r_cs_n <= 1'b0;
               r_wr_n <= 1'b0;
               if (r_cnt == LAST_WORD) begin
                  r_cnt   <= '0;
                  r_addr  <= SORT5_ADDR_START;
                  r_wdata <= '0;
                  r_state <= START;
               end else begin
                  r_cnt   <= r_cnt + 3'd1;
                  r_addr  <= SORT5_ADDR_IN0 + {1'b0, r_cnt} + 4'd1;
                  r_wdata <= r_buf[r_cnt + 3'd1];
               end
            end
            START: begin
               r_settle <= '0;
               r_state  <= SETTLE;
            end
            SETTLE: begin
               if (r_settle == SW'(SETTLE_CYCLES - 1)) begin
                  r_idx   <= RD_FIRST;
                  r_cs_n  <= 1'b0;
                  r_rd_n  <= 1'b0;
                  r_addr  <= RD_FIRST;
                  r_state <= READ;
               end else begin
                  r_settle <= r_settle + 1'b1;
               end
            end
            READ: r_state <= CAPTURE;
            CAPTURE: begin
               r_out_data  <= iReadData;
               r_out_valid <= 1'b1;
               r_out_last  <= (r_idx == RD_LAST);
               r_state     <= EMIT;
            end
            EMIT: begin
               if (iOutReady) begin
                  r_out_valid <= 1'b0;
                  r_out_last  <= 1'b0;
                  if (r_idx == RD_LAST) begin
                     r_in_ready <= 1'b1;
                     r_busy     <= 1'b0;
                     r_state    <= COLLECT;
                  end else begin
                     r_idx   <= r_idx + 4'd1;
                     r_cs_n  <= 1'b0;
                     r_rd_n  <= 1'b0;
                     r_addr  <= r_idx + 4'd1;
                     r_state <= READ;
                  end
               end
            end
            default: begin
               r_in_ready <= 1'b1;
               r_busy     <= 1'b0;
               r_state    <= COLLECT;
            end
         endcase
      end
   end

   assign oInReady      = r_in_ready;
   assign oOutValid     = r_out_valid;
   assign oOutLast      = r_out_last;
   assign oOutData      = r_out_data;
   assign oChipSelect_n = r_cs_n;
   assign oWrite_n      = r_wr_n;
   assign oRead_n       = r_rd_n;
   assign oAddress      = r_addr;
   assign oWriteData    = r_wdata;
   assign oBusy         = r_busy;

endmodule

// File: tb/tb_sort5_stream_adapter.sv
// Self-checking bench: a Sort5 slave model on the bus, a queue-based expected-output model.
// Honours SORT5_ADAPT_MEDIAN_ONLY_EN the same way as the design.
module tb_sort5_stream_adapter;

   localparam int DW     = 32;
   localparam int SETTLE = 2;
`ifdef SORT5_ADAPT_MEDIAN_ONLY_EN
   localparam int NRD = 1;
   localparam int RD0 = 8;
`else
   localparam int NRD = 5;
   localparam int RD0 = 6;
`endif

   logic          iClk = 1'b0;
   logic          iReset_n;
   logic          iInValid;
   logic          oInReady;
   logic [DW-1:0] iInData;
   logic          oOutValid;
   logic          iOutReady;
   logic [DW-1:0] oOutData;
   logic          oOutLast;
   logic          oChipSelect_n;
   logic          oWrite_n;
   logic          oRead_n;
   logic [3:0]    oAddress;
   logic [DW-1:0] oWriteData;
   logic [DW-1:0] iReadData;
   logic          oBusy;

   sort5_stream_adapter #(.DATA_WIDTH(DW), .SETTLE_CYCLES(SETTLE)) dut (
      .iClk(iClk), .iReset_n(iReset_n),
      .iInValid(iInValid), .oInReady(oInReady), .iInData(iInData),
      .oOutValid(oOutValid), .iOutReady(iOutReady), .oOutData(oOutData), .oOutLast(oOutLast),
      .oChipSelect_n(oChipSelect_n), .oWrite_n(oWrite_n), .oRead_n(oRead_n),
      .oAddress(oAddress), .oWriteData(oWriteData), .iReadData(iReadData), .oBusy(oBusy)
   );

   always #5 iClk = ~iClk;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   bit stall  = 1'b0;

   always @(posedge iClk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
   endtask

   // Sort5 slave: input regs, sorted regs loaded on the start write, registered read data.
   logic [DW-1:0]        s_in [5];
   logic [4:0][DW-1:0]   s_sorted;
   logic [DW-1:0]        s_rdata = '0;
   assign iReadData = s_rdata;

   function automatic logic [4:0][DW-1:0] sort_net(input logic [DW-1:0] a [5]);
      logic [DW-1:0] t [5];
      logic [DW-1:0] x;
      logic [4:0][DW-1:0] r;
      for (int i = 0; i < 5; i++) t[i] = a[i];
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4 - i; j++)
            if (t[j] > t[j+1]) begin x = t[j]; t[j] = t[j+1]; t[j+1] = x; end
      for (int i = 0; i < 5; i++) r[i] = t[i];
      return r;
   endfunction

   always @(posedge iClk) begin
      if (!oChipSelect_n && !oWrite_n) begin
         if (oAddress < 4'd5) s_in[oAddress[2:0]] <= oWriteData;
         else if (oAddress == 4'd5) s_sorted <= sort_net(s_in);
      end
      if (!oChipSelect_n && !oRead_n && oAddress >= 4'd6 && oAddress <= 4'd10)
         s_rdata <= s_sorted[3'(oAddress - 4'd6)];
   end

   // Expected output stream and observed bus accesses.
   typedef struct { logic [DW-1:0] d; logic l; } exp_t;
   typedef struct { int c; logic wr; logic [3:0] a; logic [DW-1:0] d; } bus_t;
   exp_t exp_q [$];
   bus_t bus_log [$];

   always @(negedge iClk) begin
      if (iReset_n) begin
         if (!oChipSelect_n) begin
            bus_log.push_back('{cyc, !oWrite_n, oAddress, oWriteData});
            chk("one_strobe", 32'(oWrite_n ^ oRead_n), 32'd1);
         end else begin
            chk("idle_strobes", 32'({oWrite_n, oRead_n}), 32'd3);
         end
         if (oOutValid) begin
            chk("inrdy_while_out", 32'(oInReady), 32'd0);
            chk("busy_while_out", 32'(oBusy), 32'd1);
            if (exp_q.size() == 0) begin
               chk("unexpected_out", 32'(oOutValid), 32'd0);
            end else begin
               chk("out_data", oOutData, exp_q[0].d);
               chk("out_last", 32'(oOutLast), 32'(exp_q[0].l));
               if (iOutReady) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge iClk); #1;
         iOutReady = stall ? ($urandom_range(0, 3) == 0) : 1'b1;
      end
   end

   task automatic push_expected(input logic [DW-1:0] w [5]);
      bit [DW-1:0] q [$];
      for (int i = 0; i < 5; i++) q.push_back(w[i]);
      q.sort();
`ifdef SORT5_ADAPT_MEDIAN_ONLY_EN
      exp_q.push_back('{q[2], 1'b1});
`else
      for (int i = 0; i < 5; i++) exp_q.push_back('{q[i], (i == 4)});
`endif
   endtask

   // Accepting input while outputs are still pending would break block ordering.
   task automatic send_block(input logic [DW-1:0] w [5]);
      int n;
      for (int i = 0; i < 5; i++) begin
         iInValid = 1'b1;
         iInData  = w[i];
         n = 0;
         while (!oInReady && n < 2000) begin @(posedge iClk); #1; n++; end
         chk("in_ready", 32'(oInReady), 32'd1);
         chk("accept_gap", 32'(exp_q.size()), 32'd0);
         @(posedge iClk); #1;
      end
      iInValid = 1'b0;
      push_expected(w);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 3000) begin @(negedge iClk); n++; end
      chk("drain", 32'(exp_q.size()), 32'd0);
      @(posedge iClk); #1;
      chk("idle_busy", 32'(oBusy), 32'd0);
      chk("idle_inrdy", 32'(oInReady), 32'd1);
   endtask

   task automatic check_bus(input logic [DW-1:0] w [5]);
      int c0;
      chk("bus_len", 32'(bus_log.size()), 32'(6 + NRD));
      if (bus_log.size() == 6 + NRD) begin
         c0 = bus_log[0].c;
         for (int i = 0; i < 6; i++) begin
            chk("wr_addr", 32'({bus_log[i].wr, bus_log[i].a}), 32'({1'b1, 4'(i)}));
            chk("wr_data", bus_log[i].d, (i < 5) ? w[i] : '0);
            chk("wr_cyc", 32'(bus_log[i].c), 32'(c0 + i));
         end
         chk("settle_gap", 32'(bus_log[6].c - bus_log[5].c), 32'(SETTLE + 1));
         for (int k = 0; k < NRD; k++)
            chk("rd_addr", 32'({bus_log[6+k].wr, bus_log[6+k].a}), 32'({1'b0, 4'(RD0 + k)}));
      end
   endtask

   task automatic run_block(input logic [DW-1:0] w [5]);
      bus_log.delete();
      send_block(w);
      wait_drain();
      check_bus(w);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [DW-1:0] blk [5];
   int n;

   initial begin
      iReset_n  = 1'b0;
      iInValid  = 1'b0;
      iInData   = '0;
      iOutReady = 1'b1;
      repeat (3) @(posedge iClk);
      #1;
      chk("rst_cs_n", 32'(oChipSelect_n), 32'd1);
      chk("rst_wr_n", 32'(oWrite_n), 32'd1);
      chk("rst_rd_n", 32'(oRead_n), 32'd1);
      chk("rst_addr", 32'(oAddress), 32'd0);
      chk("rst_wdata", oWriteData, '0);
      chk("rst_valid", 32'(oOutValid), 32'd0);
      chk("rst_last", 32'(oOutLast), 32'd0);
      chk("rst_data", oOutData, '0);
      chk("rst_busy", 32'(oBusy), 32'd0);
      iReset_n = 1'b1;
      repeat (4) @(posedge iClk);
      #1;
      chk("ready_no_effect", 32'(oOutValid), 32'd0);

      blk = '{32'd9, 32'd3, 32'd7, 32'd1, 32'd5};
      run_block(blk);
      blk = '{32'd4, 32'd4, 32'd2, 32'd4, 32'd2};
      run_block(blk);
      blk = '{32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF};
      run_block(blk);

      stall = 1'b1;
      for (int b = 0; b < 3; b++) begin
         for (int i = 0; i < 5; i++) blk[i] = (b == 1) ? DW'($urandom_range(0, 3)) : $urandom;
         run_block(blk);
      end

      // Reset while the sorter is settling abandons the block.
      stall = 1'b0;
      bus_log.delete();
      blk = '{32'd8, 32'd6, 32'd4, 32'd2, 32'd0};
      send_block(blk);
      n = 0;
      do begin @(negedge iClk); n++; end
      while (!(!oChipSelect_n && !oWrite_n && oAddress == 4'd5) && n < 200);
      chk("saw_start", 32'(oAddress), 32'd5);
      @(posedge iClk); #1;
      iReset_n = 1'b0;
      #1;
      chk("mid_rst_cs_n", 32'(oChipSelect_n), 32'd1);
      chk("mid_rst_wr_n", 32'(oWrite_n), 32'd1);
      chk("mid_rst_rd_n", 32'(oRead_n), 32'd1);
      chk("mid_rst_valid", 32'(oOutValid), 32'd0);
      chk("mid_rst_busy", 32'(oBusy), 32'd0);
      exp_q.delete();
      @(posedge iClk); #1;
      iReset_n = 1'b1;
      repeat (20) @(posedge iClk);
      #1;
      blk = '{32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
      run_block(blk);

      // Back-to-back random blocks with stalls; input must wait for the previous block to drain.
      stall = 1'b1;
      for (int b = 0; b < 4; b++) begin
         for (int i = 0; i < 5; i++) blk[i] = (b[0]) ? DW'($urandom_range(0, 7)) : $urandom;
         send_block(blk);
      end
      wait_drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
